ble_auth_rx: RTL and testbench

Front end for the Bluetooth command link: receives 8N1 serial bytes from the BLE module on RX and runs the authorisation state machine that drives pwr_up to the balance and steering logic. 'G' (0x47) powers the platform up. 'S' (0x53) requests stop, but power is removed only once the rider is off. Sits directly between the RX pin and the balance/steer enable logic in the top level.

---
 rtl/ble_auth_rx.sv | 149 ++++++++++++++
 tb/tb_ble_auth_rx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ble_auth_rx.sv
// BLE command link front end: 8N1 serial receiver feeding the power authorisation FSM.
// GO_CODE authorises power; STOP_CODE drops it once the rider has stepped off.
module ble_auth_rx #(
  parameter int          BAUD_DIV  = 2604,
  parameter logic [7:0]  GO_CODE   = 8'h47,
  parameter logic [7:0]  STOP_CODE = 8'h53
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       rider_off,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       frame_err,
  output logic       pwr_up
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] BAUD_FULL = CW'(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_HALF = CW'(BAUD_DIV / 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  typedef enum logic [1:0] {OFF, PWR1, PWR2} auth_state_t;

  rx_state_t   rx_state_reg;
  auth_state_t auth_state_reg;
  logic        rx_s1_reg, rx_s2_reg, rx_s3_reg;
  logic [CW-1:0] baud_cnt_reg;
  logic [3:0]  bit_cnt_reg;
  logic [8:0]  shift_reg;
  logic        rx_fall;

  // Preset high so reset never looks like a start-bit edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_reg <= 1'b1;
      rx_s2_reg <= 1'b1;
      rx_s3_reg <= 1'b1;
    end else begin
      rx_s1_reg <= RX;
      rx_s2_reg <= rx_s1_reg;
      rx_s3_reg <= rx_s2_reg;
    end
  end

  assign rx_fall = rx_s3_reg & ~rx_s2_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_reg <= IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      rx_data      <= 8'h00;
      rx_rdy       <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      rx_rdy    <= 1'b0;
      frame_err <= 1'b0;
      case (rx_state_reg)
        IDLE: begin
          if (rx_fall) begin
            rx_state_reg <= START;
            bit_cnt_reg  <= '0;
            baud_cnt_reg <= BAUD_HALF;
          end
        end
        START: begin
          if (baud_cnt_reg == '0) begin
            // A start bit that is high again at mid-bit was only a glitch.
            if (!rx_s2_reg) begin
              rx_state_reg <= DATA;
              baud_cnt_reg <= BAUD_FULL;
            end else begin
              rx_state_reg <= IDLE;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg - 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt_reg == '0) begin
            shift_reg    <= {rx_s2_reg, shift_reg[8:1]};
            baud_cnt_reg <= BAUD_FULL;
            bit_cnt_reg  <= bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == 4'd7)
              rx_state_reg <= STOP;
          end else begin
            baud_cnt_reg <= baud_cnt_reg - 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt_reg == '0) begin
            if (rx_s2_reg) begin
              rx_data <= shift_reg[8:1];
              rx_rdy  <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            rx_state_reg <= IDLE;
          end else begin
            baud_cnt_reg <= baud_cnt_reg - 1'b1;
          end
        end
        default: rx_state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      auth_state_reg <= OFF;
      pwr_up         <= 1'b0;
    end else begin
      case (auth_state_reg)
        OFF: begin
          if (rx_rdy && rx_data == GO_CODE) begin
            auth_state_reg <= PWR1;
            pwr_up         <= 1'b1;
          end
        end
        PWR1: begin
          if (rx_rdy && rx_data == STOP_CODE) begin
            if (rider_off) begin
              auth_state_reg <= OFF;
              pwr_up         <= 1'b0;
            end else begin
              auth_state_reg <= PWR2;
            end
          end
        end
        PWR2: begin
          // A fresh GO wins over the rider leaving in the same cycle.
          if (rx_rdy && rx_data == GO_CODE) begin
            auth_state_reg <= PWR1;
          end else if (rider_off) begin
            auth_state_reg <= OFF;
            pwr_up         <= 1'b0;
          end
        end
        default: begin
          auth_state_reg <= OFF;
          pwr_up         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ble_auth_rx.sv
// Directed bench for ble_auth_rx: serial frames with hand-computed bytes and power states.
module tb_ble_auth_rx;

  localparam int BAUD = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       RX;
  logic       rider_off;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       frame_err;
  logic       pwr_up;

  int n_tests = 0;
  int n_fail  = 0;

  // Monitor state (written only by the monitor block)
  int   rdy_cnt = 0;
  int   ferr_cnt = 0;
  int   cyc = 0;
  int   last_rdy_cyc = 0;
  logic cap_next = 1'b0;
  logic pwr_at_rdy = 1'b0;
  logic pwr_after_rdy = 1'b0;

  int   t0;
  int   r0, f0;
  logic seen;

  ble_auth_rx #(.BAUD_DIV(BAUD), .GO_CODE(8'h47), .STOP_CODE(8'h53)) dut (
    .clk       (clk),
    .rst       (rst),
    .RX        (RX),
    .rider_off (rider_off),
    .rx_data   (rx_data),
    .rx_rdy    (rx_rdy),
    .frame_err (frame_err),
    .pwr_up    (pwr_up)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    cap_next <= rx_rdy;
    if (cap_next) pwr_after_rdy <= pwr_up;
    if (rx_rdy) begin
      rdy_cnt      <= rdy_cnt + 1;
      pwr_at_rdy   <= pwr_up;
      last_rdy_cyc <= cyc;
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    RX = 1'b0;
    t0 = cyc;
    wait_cycles(BAUD);
    for (int b = 0; b < 8; b++) begin
      RX = d[b];
      wait_cycles(BAUD);
    end
    RX = stop_bit;
    wait_cycles(BAUD);
    RX = 1'b1;
    wait_cycles(2 * BAUD);
  endtask

  initial begin
    RX = 1'b1;
    rider_off = 1'b0;
    rst = 1'b1;
    wait_cycles(3);
    check("rst_pwr_up", pwr_up, 0);
    check("rst_rx_rdy", rx_rdy, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_rx_data", rx_data, 8'h00);
    rst = 1'b0;
    wait_cycles(5);

    // 1: GO powers up
    r0 = rdy_cnt;
    send_byte(8'h47, 1'b1);
    check("t1_rdy_pulses", rdy_cnt - r0, 1);
    check("t1_rx_data", rx_data, 8'h47);
    check("t1_pwr_at_rdy", pwr_at_rdy, 0);
    check("t1_pwr_after_rdy", pwr_after_rdy, 1);
    check("t1_latency_in_window", (last_rdy_cyc - t0 >= 600 && last_rdy_cyc - t0 <= 640), 1);

    // 2: STOP with rider on -> PWR2, then rider leaves
    send_byte(8'h53, 1'b1);
    check("t2_rx_data", rx_data, 8'h53);
    check("t2_pwr_held", pwr_up, 1);
    @(posedge clk); #1;
    rider_off = 1'b1;
    check("t2_pwr_before_edge", pwr_up, 1);
    wait_cycles(1);
    check("t2_pwr_after_rider_off", pwr_up, 0);

    // 3: STOP with rider already off drops power directly
    send_byte(8'h47, 1'b1);
    check("t3_go_pwr", pwr_up, 1);
    send_byte(8'h53, 1'b1);
    check("t3_pwr_at_rdy", pwr_at_rdy, 1);
    check("t3_pwr_after_rdy", pwr_after_rdy, 0);
    r0 = rdy_cnt;
    send_byte(8'h53, 1'b1);
    check("t3_second_stop_rdy", rdy_cnt - r0, 1);
    check("t3_second_stop_pwr", pwr_up, 0);
    check("t3_second_stop_data", rx_data, 8'h53);

    // 4: framing error
    r0 = rdy_cnt; f0 = ferr_cnt;
    send_byte(8'h47, 1'b0);
    check("t4_frame_err_pulses", ferr_cnt - f0, 1);
    check("t4_no_rdy", rdy_cnt - r0, 0);
    check("t4_rx_data_kept", rx_data, 8'h53);
    check("t4_pwr", pwr_up, 0);

    // 5: quarter-bit glitch, then 0xA5
    r0 = rdy_cnt; f0 = ferr_cnt;
    RX = 1'b0;
    wait_cycles(BAUD / 4);
    RX = 1'b1;
    wait_cycles(2 * BAUD);
    check("t5_glitch_no_rdy", rdy_cnt - r0, 0);
    check("t5_glitch_no_ferr", ferr_cnt - f0, 0);
    send_byte(8'hA5, 1'b1);
    check("t5_a5_rdy", rdy_cnt - r0, 1);
    check("t5_a5_data", rx_data, 8'hA5);
    check("t5_a5_pwr", pwr_up, 0);

    // 6: GO in PWR2 beats rider_off in the same cycle
    rider_off = 1'b0;
    send_byte(8'h47, 1'b1);
    send_byte(8'h53, 1'b1);
    check("t6_in_pwr2", pwr_up, 1);
    seen = 1'b0;
    fork
      send_byte(8'h47, 1'b1);
      begin
        for (int i = 0; i < 2000; i++) begin
          @(negedge clk);
          if (rx_rdy) begin
            rider_off = 1'b1;
            seen = 1'b1;
            break;
          end
        end
      end
    join
    check("t6_rdy_seen", seen, 1);
    check("t6_go_priority_pwr", pwr_up, 1);
    check("t6_pwr_after_rdy", pwr_after_rdy, 1);

    // Reset mid-byte aborts the frame and drops power at once
    r0 = rdy_cnt;
    fork
      send_byte(8'h47, 1'b1);
      begin
        wait_cycles(300);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_pwr_immediate", pwr_up, 0);
        check("t6_rst_rx_rdy", rx_rdy, 0);
      end
    join
    check("t6_rst_no_rdy", rdy_cnt - r0, 0);
    check("t6_rst_data_cleared", rx_data, 8'h00);
    rst = 1'b0;
    rider_off = 1'b0;
    wait_cycles(5);
    r0 = rdy_cnt;
    send_byte(8'h47, 1'b1);
    check("t6_clean_rdy", rdy_cnt - r0, 1);
    check("t6_clean_data", rx_data, 8'h47);
    check("t6_clean_pwr", pwr_up, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
